bip_control_unit: RTL and testbench

Multi-cycle control unit for the accumulator CPU; successor of the single-cycle opcode decoder. It latches the instruction, then sequences FETCH/EXEC/MEM_WAIT/HALT. It adds logic immediates, jumps and zero-flag branches, wait states on a slow data RAM, a resumable halt, sticky illegal-opcode detection and a retired-instruction counter. It sits between program memory and the datapath, RAM and PC.

---
 rtl/bip_control_unit_if.sv | 40 ++++
 rtl/bip_control_unit.sv | 214 +++++++++++++++++++++
 tb/tb_bip_control_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_unit_if.sv
// Control unit bus: instruction/status inputs and datapath, RAM and PC control outputs.
// master = control unit side, slave = datapath/memory side.
interface bip_control_unit_if #(
  parameter int OPBTS  = 5,
  parameter int ADBTS  = 11,
  parameter int CNTBTS = 16
);
  logic [OPBTS+ADBTS-1:0] i_instr;
  logic                   i_zero;
  logic                   i_ram_rdy;
  logic                   i_resume;

  logic                   o_ir_en;
  logic [ADBTS-1:0]       o_operand;
  logic [1:0]             o_sel_A;
  logic                   o_sel_B;
  logic [2:0]             o_alu_op;
  logic                   o_w_acc;
  logic                   o_w_ram;
  logic                   o_r_ram;
  logic                   o_w_pc;
  logic                   o_pc_sel;
  logic                   o_h_flg;
  logic                   o_illegal;
  logic [CNTBTS-1:0]      o_icount;

  modport master (
    input  i_instr, i_zero, i_ram_rdy, i_resume,
    output o_ir_en, o_operand, o_sel_A, o_sel_B, o_alu_op,
    output o_w_acc, o_w_ram, o_r_ram, o_w_pc, o_pc_sel,
    output o_h_flg, o_illegal, o_icount
  );

  modport slave (
    output i_instr, i_zero, i_ram_rdy, i_resume,
    input  o_ir_en, o_operand, o_sel_A, o_sel_B, o_alu_op,
    input  o_w_acc, o_w_ram, o_r_ram, o_w_pc, o_pc_sel,
    input  o_h_flg, o_illegal, o_icount
  );
endinterface

// File: rtl/bip_control_unit.sv
// Multi-cycle control unit for the accumulator CPU: FETCH/EXEC/MEM_WAIT/HALT.
// Ports: i_clk, i_rst_n (sync, active-low), bus (bip_control_unit_if.master).
module bip_control_unit #(
  parameter int OPBTS  = 5,
  parameter int ADBTS  = 11,
  parameter int CNTBTS = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bip_control_unit_if.master bus
);
  localparam int IRW = OPBTS + ADBTS;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic [2:0] alu;
    logic       jmp;
    logic       beq;
    logic       bne;
    logic       stop;
    logic       bad;
  } dec_t;

  state_t            state;
  state_t            state_nx;
  logic [IRW-1:0]    ir;
  logic [OPBTS-1:0]  op;
  logic              illegal_q;
  logic [CNTBTS-1:0] icount_q;
  dec_t              dec;
  logic              active;
  logic              mem;
  logic              done;

  assign op = ir[IRW-1 -: OPBTS];

  always_comb begin
    dec = '0;
    unique case (op)
      OPBTS'(0):  dec.stop = 1'b1;
      OPBTS'(1):  dec.wr = 1'b1;
      OPBTS'(2):  begin
        dec.rd  = 1'b1;
        dec.acc = 1'b1;
      end
      OPBTS'(3):  begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd1;
        dec.sel_b = 1'b1;
      end
      OPBTS'(4):  begin
        dec.rd    = 1'b1;
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
      end
      OPBTS'(5):  begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.sel_b = 1'b1;
      end
      OPBTS'(6):  begin
        dec.rd    = 1'b1;
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.alu   = 3'd1;
      end
      OPBTS'(7):  begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.sel_b = 1'b1;
        dec.alu   = 3'd1;
      end
      OPBTS'(8):  begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.sel_b = 1'b1;
        dec.alu   = 3'd2;
      end
      OPBTS'(9):  begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.sel_b = 1'b1;
        dec.alu   = 3'd3;
      end
      OPBTS'(10): begin
        dec.acc   = 1'b1;
        dec.sel_a = 2'd2;
        dec.sel_b = 1'b1;
        dec.alu   = 3'd4;
      end
      OPBTS'(11): dec.jmp = 1'b1;
      OPBTS'(12): dec.beq = 1'b1;
      OPBTS'(13): dec.bne = 1'b1;
      OPBTS'(14): dec = '0;
      default: begin
        dec.bad  = 1'b1;
        dec.stop = 1'b1;
      end
    endcase
  end

  assign active = (state == EXEC) || (state == MEM_WAIT);
  assign mem    = dec.rd | dec.wr;
  // done marks the retire cycle; HLT/illegal never retire
  assign done   = active && !dec.stop
               && (!mem || bus.i_ram_rdy);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ir        <= '0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      if (state == FETCH) begin
        ir <= bus.i_instr;
      end
      if (state == EXEC && dec.bad) begin
        illegal_q <= 1'b1;
      end
      if (done && icount_q != '1) begin
        icount_q <= icount_q + CNTBTS'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: state_nx = EXEC;
      EXEC: begin
        if (dec.stop) begin
          state_nx = HALT;
        end else if (mem && !bus.i_ram_rdy) begin
          state_nx = MEM_WAIT;
        end else begin
          state_nx = FETCH;
        end
      end
      MEM_WAIT: begin
        if (bus.i_ram_rdy) begin
          state_nx = FETCH;
        end
      end
      HALT: begin
        if (bus.i_resume) begin
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // everything is forced low while reset is held, including
  // the registered flags, so a reset mid-access drops at once
  always_comb begin
    bus.o_ir_en   = 1'b0;
    bus.o_operand = '0;
    bus.o_sel_A   = 2'd0;
    bus.o_sel_B   = 1'b0;
    bus.o_alu_op  = 3'd0;
    bus.o_w_acc   = 1'b0;
    bus.o_w_ram   = 1'b0;
    bus.o_r_ram   = 1'b0;
    bus.o_w_pc    = 1'b0;
    bus.o_pc_sel  = 1'b0;
    bus.o_h_flg   = 1'b0;
    bus.o_illegal = 1'b0;
    bus.o_icount  = '0;
    if (i_rst_n) begin
      bus.o_operand = ir[ADBTS-1:0];
      bus.o_sel_A   = dec.sel_a;
      bus.o_sel_B   = dec.sel_b;
      bus.o_alu_op  = dec.alu;
      bus.o_illegal = illegal_q;
      bus.o_icount  = icount_q;
      unique case (state)
        FETCH: bus.o_ir_en = 1'b1;
        EXEC, MEM_WAIT: begin
          bus.o_r_ram  = dec.rd;
          bus.o_w_ram  = dec.wr;
          bus.o_w_pc   = done;
          bus.o_w_acc  = done & dec.acc;
          bus.o_pc_sel = dec.jmp
                       | (dec.beq & bus.i_zero)
                       | (dec.bne & ~bus.i_zero);
        end
        HALT: begin
          bus.o_h_flg = 1'b1;
          bus.o_w_pc  = bus.i_resume;
        end
        default: bus.o_ir_en = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: opcode vector table, random instruction
// stream against an instruction-level model, reset/saturation sequences.
module tb_bip_control_unit;
  localparam int OPBTS  = 5;
  localparam int ADBTS  = 11;
  localparam int CNTBTS = 16;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic [2:0] alu;
    logic       acc;
    logic       rd;
    logic       wr;
    logic       pc;
    logic       stop;
    logic       bad;
  } exp_t;

  typedef struct {
    int          op;
    logic [10:0] opnd;
    logic        z;
    int          nw;
    exp_t        e;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_icount = 0;
  logic m_illegal = 1'b0;
  vec_t vq[$];

  always #5 clk = ~clk;

  bip_control_unit_if #(.OPBTS(OPBTS), .ADBTS(ADBTS), .CNTBTS(CNTBTS)) bus();
  bip_control_unit_if #(.OPBTS(OPBTS), .ADBTS(ADBTS), .CNTBTS(4)) bus4();

  bip_control_unit #(.OPBTS(OPBTS), .ADBTS(ADBTS), .CNTBTS(CNTBTS)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  bip_control_unit #(.OPBTS(OPBTS), .ADBTS(ADBTS), .CNTBTS(4)) dut4 (
    .i_clk  (clk),
    .i_rst_n(rst2_n),
    .bus    (bus4.master)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {ir_en, w_acc, w_pc, r_ram, w_ram, pc_sel, h_flg}
  function automatic logic [6:0] ctl();
    return {bus.o_ir_en, bus.o_w_acc, bus.o_w_pc, bus.o_r_ram,
            bus.o_w_ram, bus.o_pc_sel, bus.o_h_flg};
  endfunction

  function automatic exp_t mk(input int sa, input int sb, input int alu,
                              input int acc, input int rd, input int wr,
                              input int pc, input int stop, input int bad);
    exp_t e;
    e.sel_a = sa[1:0];
    e.sel_b = sb[0];
    e.alu   = alu[2:0];
    e.acc   = acc[0];
    e.rd    = rd[0];
    e.wr    = wr[0];
    e.pc    = pc[0];
    e.stop  = stop[0];
    e.bad   = bad[0];
    return e;
  endfunction

  // opcode-level reference: group membership from the opcode list
  function automatic exp_t model(input int op, input logic z);
    exp_t e;
    e = '0;
    e.bad   = (op > 14);
    e.stop  = (op == 0) || e.bad;
    e.rd    = op inside {2, 4, 6};
    e.wr    = (op == 1);
    e.acc   = op inside {[2:10]};
    e.sel_a = (op == 3) ? 2'd1 : (op inside {[4:10]}) ? 2'd2 : 2'd0;
    e.sel_b = op inside {3, 5, 7, 8, 9, 10};
    e.alu   = (op == 6 || op == 7) ? 3'd1 :
              (op >= 8 && op <= 10) ? 3'(op - 6) : 3'd0;
    e.pc    = (op == 11) || (op == 12 && z) || (op == 13 && !z);
    return e;
  endfunction

  task automatic add(input int op, input int opnd, input logic z,
                     input int nw, input exp_t e);
    vec_t v;
    v.op   = op;
    v.opnd = opnd[10:0];
    v.z    = z;
    v.nw   = nw;
    v.e    = e;
    vq.push_back(v);
  endtask

  // starts at the negedge opening the FETCH cycle,
  // ends at the negedge opening the next FETCH cycle
  task automatic run_instr(input int op, input logic [10:0] opnd,
                           input logic z, input int nw, input exp_t e,
                           input int hwait);
    int   nwe;
    logic last;
    logic [4:0] op5;
    op5 = op[4:0];
    nwe = (e.rd || e.wr) ? nw : 0;
    bus.i_instr   = {op5, opnd};
    bus.i_zero    = 1'($urandom);
    bus.i_ram_rdy = 1'($urandom);
    bus.i_resume  = 1'($urandom);
    #1;
    chk("fetch_ctl", ctl(), 7'b1000000);
    chk("icount", bus.o_icount, m_icount);
    chk("illegal", bus.o_illegal, m_illegal);
    @(negedge clk);
    for (int c = 0; c <= nwe; c++) begin
      bus.i_instr  = 16'($urandom);
      bus.i_zero   = (c == 0) ? z : 1'($urandom);
      bus.i_resume = 1'($urandom);
      if (e.rd || e.wr) bus.i_ram_rdy = (c == nwe);
      else bus.i_ram_rdy = 1'($urandom);
      #1;
      last = (c == nwe) && !e.stop;
      chk("operand", bus.o_operand, opnd);
      chk("sel_A", bus.o_sel_A, e.sel_a);
      chk("sel_B", bus.o_sel_B, e.sel_b);
      chk("alu_op", bus.o_alu_op, e.alu);
      chk("exec_ctl", ctl(),
          {1'b0, last & e.acc, last, e.rd, e.wr, e.pc, 1'b0});
      chk("exec_icount", bus.o_icount, m_icount);
      @(negedge clk);
    end
    if (!e.stop) begin
      if (m_icount < 65535) m_icount++;
    end else begin
      if (e.bad) m_illegal = 1'b1;
      for (int h = 0; h <= hwait; h++) begin
        bus.i_instr   = 16'($urandom);
        bus.i_zero    = 1'($urandom);
        bus.i_ram_rdy = 1'($urandom);
        bus.i_resume  = (h == hwait);
        #1;
        chk("halt_ctl", ctl(), {5'b00000, 1'b0, 1'b1} | {2'b00, h == hwait, 4'b0000});
        chk("halt_icount", bus.o_icount, m_icount);
        chk("halt_illegal", bus.o_illegal, m_illegal);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int   op;
    int   nw;
    logic z;
    bus.i_instr    = '0;
    bus.i_zero     = 1'b0;
    bus.i_ram_rdy  = 1'b1;
    bus.i_resume   = 1'b1;
    bus4.i_instr   = {5'd14, 11'd0};
    bus4.i_zero    = 1'b0;
    bus4.i_ram_rdy = 1'b0;
    bus4.i_resume  = 1'b0;

    //      op opnd z nw   sa sb alu acc rd wr pc stop bad
    add(3,  5,    0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 0));
    add(2,  'h10, 0, 3, mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    add(4,  7,    1, 1, mk(2, 0, 0, 1, 1, 0, 0, 0, 0));
    add(6,  9,    0, 0, mk(2, 0, 1, 1, 1, 0, 0, 0, 0));
    add(5,  1,    0, 0, mk(2, 1, 0, 1, 0, 0, 0, 0, 0));
    add(7,  2,    1, 0, mk(2, 1, 1, 1, 0, 0, 0, 0, 0));
    add(8,  'h7f, 0, 0, mk(2, 1, 2, 1, 0, 0, 0, 0, 0));
    add(9,  'h80, 0, 0, mk(2, 1, 3, 1, 0, 0, 0, 0, 0));
    add(10, 'h3,  0, 0, mk(2, 1, 4, 1, 0, 0, 0, 0, 0));
    add(1,  'h40, 0, 2, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    add(11, 'h55, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(12, 'h20, 1, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(12, 'h20, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(13, 'h20, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(13, 'h20, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(14, 'h7ff,0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0,  0,    0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    add(20, 'h1,  0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    add(3,  'h2a, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0, 0));

    // outputs are held low during reset
    @(negedge clk);
    #1;
    chk("rst_ctl", ctl(), 7'b0);
    chk("rst_operand", bus.o_operand, 0);
    chk("rst_icount", bus.o_icount, 0);
    chk("rst_illegal", bus.o_illegal, 0);
    chk("rst_sel", {bus.o_sel_A, bus.o_sel_B, bus.o_alu_op}, 0);

    // 4-bit counter saturates at 15 on a NOP stream
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      #1;
      if (k == 28) chk("sat_14", bus4.o_icount, 14);
      if (k == 30) chk("sat_15", bus4.o_icount, 15);
      if (k == 34) chk("sat_hold", bus4.o_icount, 15);
    end

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      run_instr(vq[i].op, vq[i].opnd, vq[i].z, vq[i].nw, vq[i].e,
                $urandom_range(0, 2));
    end

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) op = $urandom_range(0, 31);
      else op = $urandom_range(1, 14);
      nw = $urandom_range(0, 3);
      z  = 1'($urandom);
      run_instr(op, 11'($urandom), z, nw, model(op, z),
                $urandom_range(0, 2));
    end

    // reset while STO sits in MEM_WAIT
    bus.i_instr = {5'd1, 11'h33};
    #1;
    chk("sto_fetch", ctl(), 7'b1000000);
    @(negedge clk);
    bus.i_ram_rdy = 1'b0;
    #1;
    chk("sto_exec", ctl(), 7'b0000100);
    @(negedge clk);
    #1;
    chk("sto_wait", ctl(), 7'b0000100);
    rst_n = 1'b0;
    #1;
    chk("sto_rst_ctl", ctl(), 7'b0);
    chk("sto_rst_icount", bus.o_icount, 0);
    chk("sto_rst_illegal", bus.o_illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_icount  = 0;
    m_illegal = 1'b0;
    run_instr(14, 11'h0, 1'b0, 0, model(14, 1'b0), 0);
    run_instr(3, 11'h5, 1'b0, 0, model(3, 1'b0), 0);
    #1;
    chk("post_rst_icount", bus.o_icount, 2);
    chk("sat_end", bus4.o_icount, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
